pipeline_hazard_controller: RTL and testbench
=============================================

// Module: pipeline_hazard_controller
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline (F/D/X/M/W).
//  - Detects load-use hazards between DX and FD.
//  - Applies flushes when a branch or jump is taken in X.
//  - Runs the handshake with the multicycle mult/div unit, freezing F/D/X
//    and bubbling XM until the unit returns a result.
//  - Sits beside the datapath: takes decoded stage fields, drives the
//    latch enables and nop-insert selects.
// PARAMETERS
//  MD_TIMEOUT  40  max BUSY cycles before the pipeline is force-released
//  CNT_W       6   width of md_cycles; must hold MD_TIMEOUT
// PORTS
//  clock           in   1      system clock, rising edge
//  reset           in   1      asynchronous, active-low
//  d_rs, d_rt      in   5      source regs of instr in FD latch
//  d_uses_rs       in   1      FD instr reads d_rs
//  d_uses_rt       in   1      FD instr reads d_rt
//  x_is_load       in   1      DX instr is lw
//  x_rd            in   5      DX destination reg
//  x_is_multdiv    in   1      DX instr is mul or div
//  x_is_div        in   1      qualifies x_is_multdiv: 1=div, 0=mul
//  x_branch_taken  in   1      branch/jump resolved taken in X
//  md_ready        in   1      mult/div result valid (level)
//  md_start_mult   out  1      one-cycle start pulse to multiplier
//  md_start_div    out  1      one-cycle start pulse to divider
//  stall_pc        out  1      hold PC
//  stall_fd        out  1      hold FD latch
//  stall_dx        out  1      hold DX latch
//  flush_fd        out  1      load nop into FD
//  flush_dx        out  1      load nop into DX
//  bubble_xm       out  1      load nop into XM
//  md_busy         out  1      FSM in START or BUSY
//  md_cycles       out  CNT_W  BUSY-cycle count of last/current op
//  md_timeout      out  1      sticky: an op hit MD_TIMEOUT
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, md_cycles=0, md_timeout=0.
//   All outputs are 0 while inputs are 0. Reset mid-op aborts it; no start re-issued.
//  FSM states: IDLE, BUSY, DONE. Outputs are combinational from state+inputs.
//  IDLE:
//   - x_is_multdiv=1 and x_branch_taken=0:
//     assert md_start_div (x_is_div=1) or md_start_mult (else) this cycle only;
//     assert stall_pc/fd/dx and bubble_xm; next=BUSY; md_cycles<=0.
//  BUSY:
//   - stall_pc/fd/dx=1, bubble_xm=1, md_busy=1; md_cycles increments every edge.
//   - md_ready=1 -> DONE.
//   - md_cycles reaching MD_TIMEOUT without md_ready -> DONE, md_timeout<=1.
//   - md_ready is sampled only in BUSY; a ready seen in the IDLE start cycle is ignored.
//  DONE (1 cycle): all stalls low; the mul/div advances to XM with its result.
//   x_is_multdiv is ignored (no restart of the same instr). next=IDLE.
//  Load-use (IDLE, no start): x_is_load & x_rd!=0 & ((d_uses_rs & d_rs==x_rd)
//   | (d_uses_rt & d_rt==x_rd)) -> stall_pc=stall_fd=1, flush_dx=1. Zero latency.
//  Branch: x_branch_taken=1 -> flush_fd=flush_dx=1 same cycle.
//   Overrides load-use (no stall) and blocks a mul/div start.
//  md_cycles holds its value after DONE until the next start.
//  md_timeout clears only on reset.
// TESTING
//  T1 x_is_multdiv=1,x_is_div=0 @c0; md_ready on 16th BUSY cycle -> md_start_mult=1 only c0;
//     stalls+bubble_xm high c0..c16; DONE c17 (stalls low, md_cycles=16); IDLE c18
//  T2 x_is_load=1,x_rd=5,d_rs=5,d_uses_rs=1 -> stall_pc=stall_fd=flush_dx=1 same cycle;
//     repeat with x_rd=0 -> all 0
//  T3 T2 stimulus plus x_branch_taken=1 -> flush_fd=flush_dx=1, stall_pc=stall_fd=0
//  T4 div start, md_ready never -> DONE after 40 BUSY cycles, md_timeout=1;
//     stays 1 through next op until reset=0
//  T5 reset=0 asserted mid-BUSY -> md_busy=0, md_cycles=0, stalls 0 immediately (no edge);
//     no start pulse after release
//  T6 x_is_multdiv held 1 through DONE, then new mul in IDLE -> no pulse in DONE;
//     single fresh pulse in IDLE

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use interlock, taken-branch
// flushes and the start/wait handshake with the multicycle mult/div unit.
module pipeline_hazard_controller #(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       d_rs,
    input  logic [4:0]       d_rt,
    input  logic             d_uses_rs,
    input  logic             d_uses_rt,
    input  logic             x_is_load,
    input  logic [4:0]       x_rd,
    input  logic             x_is_multdiv,
    input  logic             x_is_div,
    input  logic             x_branch_taken,
    input  logic             md_ready,
    output logic             md_start_mult,
    output logic             md_start_div,
    output logic             stall_pc,
    output logic             stall_fd,
    output logic             stall_dx,
    output logic             flush_fd,
    output logic             flush_dx,
    output logic             bubble_xm,
    output logic             md_busy,
    output logic [CNT_W-1:0] md_cycles,
    output logic             md_timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_md_cycles;
    logic             r_md_timeout;

    logic w_start;
    logic w_in_busy;
    logic w_hold;
    logic w_load_use;
    logic w_lu_stall;
    logic w_hit_limit;

    // Outputs are gated by reset so the pipeline is released the instant reset drops.
    assign w_start     = reset && (r_state == IDLE) && x_is_multdiv && !x_branch_taken;
    assign w_in_busy   = reset && (r_state == BUSY);
    assign w_hold      = w_start || w_in_busy;
    assign w_load_use  = x_is_load && (x_rd != 5'd0) &&
                         ((d_uses_rs && (d_rs == x_rd)) || (d_uses_rt && (d_rt == x_rd)));
    assign w_lu_stall  = reset && (r_state == IDLE) && !w_start && !x_branch_taken && w_load_use;
    assign w_hit_limit = (r_md_cycles == CNT_W'(MD_TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_md_cycles  <= '0;
            r_md_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state     <= BUSY;
                        r_md_cycles <= '0;
                    end
                end
                BUSY: begin
                    r_md_cycles <= r_md_cycles + CNT_W'(1);
                    if (md_ready) begin
                        r_state <= DONE;
                    end else if (w_hit_limit) begin
                        r_state      <= DONE;
                        r_md_timeout <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        md_start_mult = w_start && !x_is_div;
        md_start_div  = w_start && x_is_div;
        stall_pc      = w_hold || w_lu_stall;
        stall_fd      = w_hold || w_lu_stall;
        stall_dx      = w_hold;
        bubble_xm     = w_hold;
        md_busy       = w_hold;
        flush_fd      = reset && x_branch_taken;
        flush_dx      = (reset && x_branch_taken) || w_lu_stall;
    end

    assign md_cycles  = r_md_cycles;
    assign md_timeout = r_md_timeout;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: inputs change 1ns after each rising
// edge, outputs are compared at the falling edge against hand-derived vectors.
module tb_pipeline_hazard_controller;

    localparam int MD_TIMEOUT = 40;
    localparam int CNT_W      = 6;

    // Output vector order: {mult, div, stall_pc, stall_fd, stall_dx, flush_fd, flush_dx, bubble_xm, busy}
    localparam logic [8:0] O_NONE      = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] O_START_MUL = 9'b1_0_1_1_1_0_0_1_1;
    localparam logic [8:0] O_START_DIV = 9'b0_1_1_1_1_0_0_1_1;
    localparam logic [8:0] O_BUSY      = 9'b0_0_1_1_1_0_0_1_1;
    localparam logic [8:0] O_LOADUSE   = 9'b0_0_1_1_0_0_1_0_0;
    localparam logic [8:0] O_BRANCH    = 9'b0_0_0_0_0_1_1_0_0;

    logic             clock;
    logic             reset;
    logic [4:0]       d_rs;
    logic [4:0]       d_rt;
    logic             d_uses_rs;
    logic             d_uses_rt;
    logic             x_is_load;
    logic [4:0]       x_rd;
    logic             x_is_multdiv;
    logic             x_is_div;
    logic             x_branch_taken;
    logic             md_ready;
    logic             md_start_mult;
    logic             md_start_div;
    logic             stall_pc;
    logic             stall_fd;
    logic             stall_dx;
    logic             flush_fd;
    logic             flush_dx;
    logic             bubble_xm;
    logic             md_busy;
    logic [CNT_W-1:0] md_cycles;
    logic             md_timeout;

    logic [8:0] outs;
    int checkCount;
    int errorCount;

    assign outs = {md_start_mult, md_start_div, stall_pc, stall_fd, stall_dx,
                   flush_fd, flush_dx, bubble_xm, md_busy};

    pipeline_hazard_controller #(
        .MD_TIMEOUT(MD_TIMEOUT),
        .CNT_W     (CNT_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .d_rs          (d_rs),
        .d_rt          (d_rt),
        .d_uses_rs     (d_uses_rs),
        .d_uses_rt     (d_uses_rt),
        .x_is_load     (x_is_load),
        .x_rd          (x_rd),
        .x_is_multdiv  (x_is_multdiv),
        .x_is_div      (x_is_div),
        .x_branch_taken(x_branch_taken),
        .md_ready      (md_ready),
        .md_start_mult (md_start_mult),
        .md_start_div  (md_start_div),
        .stall_pc      (stall_pc),
        .stall_fd      (stall_fd),
        .stall_dx      (stall_dx),
        .flush_fd      (flush_fd),
        .flush_dx      (flush_dx),
        .bubble_xm     (bubble_xm),
        .md_busy       (md_busy),
        .md_cycles     (md_cycles),
        .md_timeout    (md_timeout)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic multdiv, input logic isDiv, input logic ready,
                                 input logic branch, input logic load, input logic [4:0] xrd,
                                 input logic [4:0] rs, input logic usesRs,
                                 input logic [4:0] rt, input logic usesRt);
        x_is_multdiv   = multdiv;
        x_is_div       = isDiv;
        md_ready       = ready;
        x_branch_taken = branch;
        x_is_load      = load;
        x_rd           = xrd;
        d_rs           = rs;
        d_uses_rs      = usesRs;
        d_rt           = rt;
        d_uses_rt      = usesRt;
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        #12;
        checkOutput("reset_outs", 32'(outs), 32'(O_NONE));
        checkOutput("reset_cycles", 32'(md_cycles), 32'd0);
        checkOutput("reset_timeout", 32'(md_timeout), 32'd0);
        #1 reset = 1'b1;

        // Load-use interlock on rs and rt, and the cases that must not stall.
        nextCycle();
        applyStimulus(0, 0, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0);
        @(negedge clock) checkOutput("lu_rs", 32'(outs), 32'(O_LOADUSE));
        nextCycle();
        applyStimulus(0, 0, 0, 0, 1, 5'd7, 5'd3, 1, 5'd7, 1);
        @(negedge clock) checkOutput("lu_rt", 32'(outs), 32'(O_LOADUSE));
        nextCycle();
        applyStimulus(0, 0, 0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 1);
        @(negedge clock) checkOutput("lu_r0", 32'(outs), 32'(O_NONE));
        nextCycle();
        applyStimulus(0, 0, 0, 0, 1, 5'd6, 5'd5, 1, 5'd4, 1);
        @(negedge clock) checkOutput("lu_nomatch", 32'(outs), 32'(O_NONE));
        nextCycle();
        applyStimulus(0, 0, 0, 0, 1, 5'd5, 5'd5, 0, 5'd0, 0);
        @(negedge clock) checkOutput("lu_unused", 32'(outs), 32'(O_NONE));
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 5'd5, 5'd5, 1, 5'd0, 0);
        @(negedge clock) checkOutput("lu_notload", 32'(outs), 32'(O_NONE));

        // Taken branch overrides load-use and blocks a mul/div start.
        nextCycle();
        applyStimulus(0, 0, 0, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0);
        @(negedge clock) checkOutput("br_over_lu", 32'(outs), 32'(O_BRANCH));
        nextCycle();
        applyStimulus(1, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        @(negedge clock) checkOutput("br_blocks_md", 32'(outs), 32'(O_BRANCH));
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        @(negedge clock) checkOutput("br_stay_idle", 32'(outs), 32'(O_NONE));

        // Multiply with ready on the 16th busy cycle; multdiv held high through DONE.
        nextCycle();
        applyStimulus(1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        @(negedge clock) checkOutput("mul_c0", 32'(outs), 32'(O_START_MUL));
        for (int i = 1; i <= 16; i++) begin
            nextCycle();
            md_ready = (i == 16);
            @(negedge clock);
            checkOutput($sformatf("mul_busy%0d", i), 32'(outs), 32'(O_BUSY));
            checkOutput($sformatf("mul_cnt%0d", i), 32'(md_cycles), 32'(i - 1));
        end
        nextCycle();
        md_ready = 1'b0;
        @(negedge clock);
        checkOutput("mul_done", 32'(outs), 32'(O_NONE));
        checkOutput("mul_done_cnt", 32'(md_cycles), 32'd16);
        nextCycle();
        @(negedge clock) checkOutput("mul_fresh_start", 32'(outs), 32'(O_START_MUL));
        nextCycle();
        md_ready = 1'b1;
        @(negedge clock) checkOutput("mul2_busy", 32'(outs), 32'(O_BUSY));
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        @(negedge clock);
        checkOutput("mul2_done", 32'(outs), 32'(O_NONE));
        checkOutput("mul2_cnt", 32'(md_cycles), 32'd1);
        nextCycle();
        @(negedge clock) checkOutput("mul2_idle", 32'(outs), 32'(O_NONE));

        // A ready already high in the start cycle is not taken as completion.
        nextCycle();
        applyStimulus(1, 1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        @(negedge clock) checkOutput("rdy_start", 32'(outs), 32'(O_START_DIV));
        nextCycle();
        @(negedge clock);
        checkOutput("rdy_busy", 32'(outs), 32'(O_BUSY));
        checkOutput("rdy_busy_cnt", 32'(md_cycles), 32'd0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        @(negedge clock);
        checkOutput("rdy_done", 32'(outs), 32'(O_NONE));
        checkOutput("rdy_done_cnt", 32'(md_cycles), 32'd1);

        // Divide that never completes: forced release after MD_TIMEOUT busy cycles.
        nextCycle();
        applyStimulus(1, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        @(negedge clock) checkOutput("div_c0", 32'(outs), 32'(O_START_DIV));
        for (int i = 1; i <= MD_TIMEOUT; i++) begin
            nextCycle();
            @(negedge clock);
            checkOutput($sformatf("div_busy%0d", i), 32'(outs), 32'(O_BUSY));
        end
        checkOutput("div_last_cnt", 32'(md_cycles), 32'(MD_TIMEOUT - 1));
        checkOutput("div_last_tmo", 32'(md_timeout), 32'd0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        @(negedge clock);
        checkOutput("div_done", 32'(outs), 32'(O_NONE));
        checkOutput("div_done_cnt", 32'(md_cycles), 32'(MD_TIMEOUT));
        checkOutput("div_done_tmo", 32'(md_timeout), 32'd1);

        // Timeout flag survives a later successful op.
        nextCycle();
        applyStimulus(1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        @(negedge clock) checkOutput("post_tmo_start", 32'(outs), 32'(O_START_MUL));
        nextCycle();
        applyStimulus(1, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        @(negedge clock) checkOutput("post_tmo_busy", 32'(outs), 32'(O_BUSY));
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        @(negedge clock);
        checkOutput("post_tmo_done", 32'(outs), 32'(O_NONE));
        checkOutput("post_tmo_sticky", 32'(md_timeout), 32'd1);

        // Asynchronous reset in the middle of a busy op.
        nextCycle();
        applyStimulus(1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        @(negedge clock) checkOutput("rst_op_start", 32'(outs), 32'(O_START_MUL));
        nextCycle();
        nextCycle();
        @(negedge clock);
        checkOutput("rst_op_busy", 32'(outs), 32'(O_BUSY));
        checkOutput("rst_op_cnt", 32'(md_cycles), 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("rst_mid_outs", 32'(outs), 32'(O_NONE));
        checkOutput("rst_mid_cnt", 32'(md_cycles), 32'd0);
        checkOutput("rst_mid_tmo", 32'(md_timeout), 32'd0);
        x_is_multdiv = 1'b0;
        #4 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            @(negedge clock) checkOutput($sformatf("rst_release%0d", i), 32'(outs), 32'(O_NONE));
        end
        nextCycle();
        applyStimulus(1, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        @(negedge clock) checkOutput("rst_recover", 32'(outs), 32'(O_START_DIV));

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
